// File: rtl/spart_uart_rx_if.sv
// Purpose : bus bundle between the SPART queue logic and the 8N1 receive front end.
// Signals : RX        - UART RX pin level (asynchronous to clk, idles high)
//           baud      - clocks per bit, CNT_W bits wide (SPART DB register)
//           rx_data   - last good byte received
//           rdy       - one-cycle pulse, rx_data is new
//           frame_err - one-cycle pulse, stop bit sampled low
//           busy      - receiver is not idle
// Modports: master = SPART side (drives RX/baud), slave = receiver (drives results).
interface spart_uart_rx_if #(
    parameter int unsigned CNT_W = 13
);
    logic             RX;
    logic [CNT_W-1:0] baud;
    logic [7:0]       rx_data;
    logic             rdy;
    logic             frame_err;
    logic             busy;

    modport master (
        output RX, baud,
        input  rx_data, rdy, frame_err, busy
    );

    modport slave (
        input  RX, baud,
        output rx_data, rdy, frame_err, busy
    );
endinterface

// File: rtl/spart_uart_rx.sv
// Purpose : SPART serial receive front end. Deserialises 8N1 frames from the RX pin
//           into bytes, pulses rdy with the byte, pulses frame_err on a low stop bit.
// Ports   : clk - system clock
//           rst - asynchronous active-high reset
//           bus - spart_uart_rx_if.slave (RX, baud in; rx_data, rdy, frame_err, busy out)
// Config  : define SPART_RX_MAJORITY_EN to take every bit sample as the 2-of-3 majority
//           of the synchronised line at cnt==2, 1 and 0 (same sampling instant/latency).
//           Undefined (default): single sample of the synchronised line at cnt==0.
module spart_uart_rx #(
    parameter int unsigned CNT_W    = 13,
    parameter int unsigned MIN_BAUD = 4
) (
    input  logic           clk,
    input  logic           rst,
    spart_uart_rx_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [1:0]       sync_q,    sync_d;
    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       idx_q,     idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rdy_q,     rdy_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q,    busy_d;

    logic             rxs;
    logic             sample_c;
    logic [CNT_W-1:0] b_c;

    // Synchronised line level; every decision uses this.
    assign rxs = sync_q[1];

    // Divisor clamped to the smallest workable bit period.
    assign b_c = (bus.baud < CNT_W'(MIN_BAUD)) ? CNT_W'(MIN_BAUD) : bus.baud;

`ifdef SPART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;
    logic       counting_c;

    assign counting_c = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    // History of the two samples preceding the cnt==0 instant; cleared whenever cnt reloads.
    always_comb begin
        hist_d = hist_q;
        if ((state_q == IDLE && !rxs) || (counting_c && cnt_q == '0)) begin
            hist_d = 2'b00;
        end else if (counting_c && (cnt_q == CNT_W'(2) || cnt_q == CNT_W'(1))) begin
            hist_d = {hist_q[0], rxs};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= 2'b00;
        else     hist_q <= hist_d;
    end

    assign sample_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
    assign sample_c = rxs;
`endif

    // Next-state and output logic.
    always_comb begin
        sync_d      = {sync_q[0], bus.RX};
        state_d     = state_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rdy_d       = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    // Period is frozen here so mid-frame baud writes cannot skew the frame.
                    period_d = b_c;
                    cnt_d    = (b_c >> 1) - CNT_W'(1);
                    state_d  = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (sample_c) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = period_q - CNT_W'(1);
                        idx_d   = 3'd0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sample_c, shift_q[7:1]};
                    cnt_d   = period_q - CNT_W'(1);
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (sample_c) begin
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                // A break or stuck-low line must go high before a new start is armed.
                if (rxs) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            period_q    <= '0;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule
